// File: rtl/shift595_pkg.sv
// Shared types for the 74HC595-style serial receiver.
// Receiver FSM states and default synchroniser depth.
package shift595_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } rx_state_t;

    localparam int SYNC_STAGES_DEF = 2;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/shift_595_rx_sync_edge_det.sv
// Async input synchroniser with rising-edge detect (module sync_edge_det).
// Ports: clk, rst_n, async_in -> level (synced/filtered), rise (1-clk pulse).
// Optional level filter when SHIFT_RX_DEGLITCH_EN is defined.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
`ifdef SHIFT_RX_DEGLITCH_EN
    ,
    parameter int DEGLITCH_LEN = 4
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

`ifdef SHIFT_RX_DEGLITCH_EN
    localparam int DGW = $clog2(DEGLITCH_LEN + 1);

    logic           filt_q;
    logic           filt_d;
    logic [DGW-1:0] dg_cnt_q;
    logic [DGW-1:0] dg_cnt_d;

    // Filtered level flips only after the synced level has disagreed
    // with it for DEGLITCH_LEN consecutive cycles.
    always_comb begin
        filt_d   = filt_q;
        dg_cnt_d = '0;
        if (synced != filt_q) begin
            if (dg_cnt_q == DGW'(DEGLITCH_LEN - 1)) begin
                filt_d = synced;
            end else begin
                dg_cnt_d = dg_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q   <= 1'b0;
            dg_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            dg_cnt_q <= dg_cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = synced;
`endif

    always_comb begin
        prev_d = level;
    end

    assign rise = level & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/shift_595_rx.sv
// Receive end of a 3-wire 595 link: MSB-first shift on SCLK rise, latch on RCLK rise.
// Ports: clk, rst_n, SCLK, DIO, RCLK -> data_out[WIDTH], data_valid, frame_err, busy.
// Optional input deglitch filter: define SHIFT_RX_DEGLITCH_EN.
module shift_595_rx
    import shift595_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef SHIFT_RX_DEGLITCH_EN
    ,
    parameter int DEGLITCH_LEN = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCLK,
    input  logic             DIO,
    input  logic             RCLK,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic sclk_rise;
    logic rclk_rise;
    logic dio_s;
    logic sclk_level_unused;
    logic rclk_level_unused;
    logic dio_rise_unused;

`ifdef SHIFT_RX_DEGLITCH_EN
    sync_edge_det #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEGLITCH_LEN (DEGLITCH_LEN)
    ) u_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SCLK),
        .level    (sclk_level_unused),
        .rise     (sclk_rise)
    );

    sync_edge_det #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEGLITCH_LEN (DEGLITCH_LEN)
    ) u_dio (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (DIO),
        .level    (dio_s),
        .rise     (dio_rise_unused)
    );

    sync_edge_det #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEGLITCH_LEN (DEGLITCH_LEN)
    ) u_rclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (RCLK),
        .level    (rclk_level_unused),
        .rise     (rclk_rise)
    );
`else
    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SCLK),
        .level    (sclk_level_unused),
        .rise     (sclk_rise)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dio (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (DIO),
        .level    (dio_s),
        .rise     (dio_rise_unused)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (RCLK),
        .level    (rclk_level_unused),
        .rise     (rclk_rise)
    );
`endif

    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [WIDTH-1:0] shift_reg_q;
    logic [WIDTH-1:0] shift_reg_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic             data_valid_q;
    logic             data_valid_d;
    logic             frame_err_q;
    logic             frame_err_d;

    // Datapath: a simultaneous latch sees the pre-shift register, like
    // the 595 storage register lagging the shift register by one edge.
    always_comb begin
        shift_reg_d  = shift_reg_q;
        bit_cnt_d    = bit_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = frame_err_q;

        if (sclk_rise) begin
            shift_reg_d = {shift_reg_q[WIDTH-2:0], dio_s};
            if (bit_cnt_q != CNT_W'(WIDTH + 1)) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (rclk_rise) begin
            data_out_d   = shift_reg_q;
            data_valid_d = 1'b1;
            frame_err_d  = (bit_cnt_q != CNT_W'(WIDTH));
            bit_cnt_d    = sclk_rise ? CNT_W'(1) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sclk_rise) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (rclk_rise) begin
                    state_d = sclk_rise ? SHIFT : IDLE;
                end else if (sclk_rise && bit_cnt_q == CNT_W'(WIDTH)) begin
                    state_d = OVER;
                end
            end
            OVER: begin
                if (rclk_rise) begin
                    state_d = sclk_rise ? SHIFT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_reg_q  <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_reg_q  <= shift_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
